// File: rtl/instruction_memory_arbiter_if.sv
// Bus bundle between the instruction memory arbiter and its neighbours:
// fetch side, loader side and the single-port instruction memory.
interface instruction_memory_arbiter_if;
  logic        leer_siguiente_inst;
  logic [13:0] direccion_siguiente_inst;
  logic        lectura_completada;
  logic [31:0] instruccion_actual;
  logic        carga_valida;
  logic [13:0] carga_direccion;
  logic [31:0] carga_dato;
  logic        carga_lista;
  logic [13:0] mem_direccion;
  logic        mem_escribir;
  logic [31:0] mem_dato_escritura;
  logic [31:0] mem_dato_lectura;
  logic        fin_programa;
  logic        error_solapamiento;
  logic [15:0] instrucciones_leidas;

  modport slave (
    input  leer_siguiente_inst, direccion_siguiente_inst,
    input  carga_valida, carga_direccion, carga_dato,
    input  mem_dato_lectura,
    output lectura_completada, instruccion_actual, carga_lista,
    output mem_direccion, mem_escribir, mem_dato_escritura,
    output fin_programa, error_solapamiento, instrucciones_leidas
  );

  modport master (
    output leer_siguiente_inst, direccion_siguiente_inst,
    output carga_valida, carga_direccion, carga_dato,
    output mem_dato_lectura,
    input  lectura_completada, instruccion_actual, carga_lista,
    input  mem_direccion, mem_escribir, mem_dato_escritura,
    input  fin_programa, error_solapamiento, instrucciones_leidas
  );
endinterface

// File: rtl/instruction_memory_arbiter.sv
// Shares one instruction memory port between the program-counter fetch path
// and the program loader, alternating grants when both are waiting.
module instruction_memory_arbiter #(
  parameter int LATENCIA_LECTURA = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         reiniciar,
  instruction_memory_arbiter_if.slave  bus
);

  localparam logic [1:0]  REPOSO      = 2'd0;
  localparam logic [1:0]  LEYENDO     = 2'd1;
  localparam logic [1:0]  ESCRIBIENDO = 2'd2;
  localparam logic [2:0]  LATENCIA    = LATENCIA_LECTURA[2:0];
  localparam logic [31:0] HALT_WORD   = 32'hFFFF_FFFF;

  function automatic logic is_halt(input logic [31:0] word);
    return (word == HALT_WORD);
  endfunction

  logic [1:0]  state_r;
  logic [2:0]  cnt_r;
  logic        pend_r;
  logic [13:0] addr_lat_r;
  logic        last_fetch_r;
  logic        lc_r;
  logic [31:0] instr_r;
  logic [13:0] mem_dir_r;
  logic        mem_wr_r;
  logic [31:0] mem_wdata_r;
  logic        fin_r;
  logic        err_r;
  logic [15:0] count_r;

  logic fetch_req_s;
  logic grant_loader_s;
  logic carga_lista_s;
  logic write_go_s;
  logic read_go_s;

  // Request qualification and grant decision for the current cycle.
  always_comb begin
    fetch_req_s    = bus.leer_siguiente_inst && !fin_r;
    grant_loader_s = !pend_r || (bus.carga_valida && last_fetch_r);
    carga_lista_s  = (state_r == REPOSO) && grant_loader_s;
    write_go_s     = bus.carga_valida && carga_lista_s;
    // A restart on the grant edge wins over the pending fetch.
    read_go_s      = (state_r == REPOSO) && pend_r && !grant_loader_s && !reiniciar;
  end

  // One-deep fetch buffer; a second request while it is full is dropped and flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r     <= 1'b0;
      addr_lat_r <= 14'd0;
      err_r      <= 1'b0;
    end else if (reiniciar) begin
      pend_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      if (read_go_s) begin
        pend_r <= 1'b0;
      end else if (fetch_req_s && !pend_r) begin
        pend_r     <= 1'b1;
        addr_lat_r <= bus.direccion_siguiente_inst;
      end else begin
        pend_r <= pend_r;
      end
      if (fetch_req_s && pend_r) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // Memory-port state machine: issues reads and writes and captures read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= REPOSO;
      cnt_r        <= 3'd0;
      last_fetch_r <= 1'b0;
      lc_r         <= 1'b0;
      instr_r      <= 32'd0;
      mem_dir_r    <= 14'd0;
      mem_wr_r     <= 1'b0;
      mem_wdata_r  <= 32'd0;
      fin_r        <= 1'b0;
      count_r      <= 16'd0;
    end else begin
      lc_r <= 1'b0;
      if (reiniciar) begin
        fin_r   <= 1'b0;
        count_r <= 16'd0;
      end
      case (state_r)
        REPOSO: begin
          if (write_go_s) begin
            mem_dir_r    <= bus.carga_direccion;
            mem_wdata_r  <= bus.carga_dato;
            mem_wr_r     <= 1'b1;
            last_fetch_r <= 1'b0;
            state_r      <= ESCRIBIENDO;
          end else if (read_go_s) begin
            mem_dir_r    <= addr_lat_r;
            cnt_r        <= LATENCIA;
            last_fetch_r <= 1'b1;
            state_r      <= LEYENDO;
          end else begin
            state_r <= REPOSO;
          end
        end
        LEYENDO: begin
          if (reiniciar) begin
            state_r <= REPOSO;
          end else if (cnt_r == 3'd1) begin
            instr_r <= bus.mem_dato_lectura;
            lc_r    <= 1'b1;
            if (is_halt(bus.mem_dato_lectura)) begin
              fin_r <= 1'b1;
            end
            if (count_r != 16'hFFFF) begin
              count_r <= count_r + 16'd1;
            end
            state_r <= REPOSO;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        ESCRIBIENDO: begin
          mem_wr_r <= 1'b0;
          state_r  <= REPOSO;
        end
        default: begin
          mem_wr_r <= 1'b0;
          state_r  <= REPOSO;
        end
      endcase
    end
  end

  assign bus.lectura_completada   = lc_r;
  assign bus.instruccion_actual   = instr_r;
  assign bus.carga_lista          = carga_lista_s;
  assign bus.mem_direccion        = mem_dir_r;
  assign bus.mem_escribir         = mem_wr_r;
  assign bus.mem_dato_escritura   = mem_wdata_r;
  assign bus.fin_programa         = fin_r;
  assign bus.error_solapamiento   = err_r;
  assign bus.instrucciones_leidas = count_r;

endmodule
